// File: rtl/instr_sequencer_pkg.sv
// Shared constants and types for the instruction sequencer that feeds core_cpu.
// Widths here must stay in step with core_cpu data_in.
package instr_sequencer_pkg;
  localparam int INSTR_W = 20;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = $clog2(DEPTH);

  localparam logic [INSTR_W-1:0] NOP_INSTR  = '0;
  localparam logic [ADDR_W:0]    COUNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]    COUNT_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;
endpackage

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the pad-side controller (master) and the sequencer (slave).
// Write handshake: a word transfers on a rising edge where wr_valid && wr_ready are both high.
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic               wr_valid;
  logic [INSTR_W-1:0] wr_data;
  logic               wr_ready;
  logic               clr;
  logic               start;
  logic               stop;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W:0]    count;
  logic               busy;
  logic               done;
  seq_state_t         state;

  modport master (
    output wr_valid, wr_data, clr, start, stop,
    input  wr_ready, instr_out, instr_valid, pc, count, busy, done, state
  );

  modport slave (
    input  wr_valid, wr_data, clr, start, stop,
    output wr_ready, instr_out, instr_valid, pc, count, busy, done, state
  );
endinterface

// File: rtl/instr_sequencer_store.sv
// Program store: register array with synchronous write and asynchronous read.
// Contents are deliberately not reset; the count in the sequencer defines what is valid.
module instr_sequencer_store #(
  parameter int INSTR_W = 20,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// Captures a short program over the write port, then replays it one word per cycle
// on instr_out with a one-cycle done pulse after the last word.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic               pad_clk,
  input  logic               pad_rst_n,
  instr_sequencer_if.slave   bus
);
  seq_state_t         state_q, state_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, rd_addr;
  logic [INSTR_W-1:0] instr_q, instr_d, rd_data;
  logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic               wr_ok, wr_acc, last;

  assign wr_ok  = (state_q == IDLE) && (count_q < COUNT_FULL) && !bus.clr;
  assign wr_acc = bus.wr_valid && wr_ok;
  assign last   = ({1'b0, pc_q} == (count_q - COUNT_ONE));

  // Read address looks one word ahead so instr_out can be registered.
  assign rd_addr = (state_q == RUN) ? (pc_q + ADDR_W'(1)) : '0;

  instr_sequencer_store #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_store (
    .clk   (pad_clk),
    .we    (wr_acc),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pc_d    = pc_q;
    instr_d = NOP_INSTR;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          count_d = '0;
        end else begin
          if (wr_acc) count_d = count_q + COUNT_ONE;
          if (bus.start && ((count_q != '0) || wr_acc)) begin
            state_d = RUN;
            pc_d    = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            // An empty store plus a same-cycle write: word 0 is still in flight.
            instr_d = (count_q == '0) ? bus.wr_data : rd_data;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          instr_d = rd_data;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pad_clk or negedge pad_rst_n) begin
    if (!pad_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.wr_ready    = wr_ok;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.count       = count_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected replay words and done
// pulses into exp_q; a negedge monitor pops and compares whenever the DUT presents output.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int SW = 3 + ADDR_W + INSTR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if bus();

  instr_sequencer dut (
    .pad_clk   (clk),
    .pad_rst_n (rst_n),
    .bus       (bus)
  );

  logic [SW-1:0]      exp_q[$];
  logic [SW-1:0]      mon_act, mon_exp;
  logic [INSTR_W-1:0] model_mem [DEPTH];
  int                 model_count = 0;
  int                 checks = 0;
  int                 errors = 0;

  // ---------------- scoreboard helpers ----------------
  function automatic logic [SW-1:0] exp_instr(input int i);
    return {1'b1, 1'b1, 1'b0, ADDR_W'(i), model_mem[i]};
  endfunction

  function automatic logic [SW-1:0] exp_done();
    return {1'b0, 1'b0, 1'b1, ADDR_W'(model_count - 1), NOP_INSTR};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.instr_valid || bus.done) begin
      mon_act = {bus.busy, bus.instr_valid, bus.done, bus.pc, bus.instr_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h expected no output", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL replay_word: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic write_word(input logic [INSTR_W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    if (model_count < DEPTH) begin
      model_mem[model_count] = d;
      model_count++;
    end
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic clear();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    model_count = 0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_instr(i));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic start_run(input string name);
    push_words(model_count);
    exp_q.push_back(exp_done());
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    drain(name);
    chk({name, "_idle_after"}, 32'(bus.state), 32'(IDLE));
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.clr      = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;

    #12;
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr_out",   32'(bus.instr_out),   32'd0);
    chk("rst_pc",          32'(bus.pc),          32'd0);
    chk("rst_count",       32'(bus.count),       32'd0);
    chk("rst_busy",        32'(bus.busy),        32'd0);
    chk("rst_done",        32'(bus.done),        32'd0);
    chk("rst_wr_ready",    32'(bus.wr_ready),    32'd1);
    chk("rst_state",       32'(bus.state),       32'(IDLE));
    rst_n = 1'b1;
    step();

    // 1: three-word program
    write_word(20'h12345);
    write_word(20'hABCDE);
    write_word(20'h0000F);
    chk("t1_count", 32'(bus.count), 32'd3);
    start_run("t1_replay");
    chk("t1_count_kept", 32'(bus.count), 32'd3);

    // 2: fill to DEPTH, overflow write dropped, full replay
    clear();
    for (int i = 0; i < DEPTH; i++) write_word(20'(32'h10000 + i * 32'h111));
    chk("t2_count_full", 32'(bus.count), 32'd16);
    chk("t2_wr_ready_full", 32'(bus.wr_ready), 32'd0);
    write_word(20'hFFFFF);
    chk("t2_count_after_overflow", 32'(bus.count), 32'd16);
    start_run("t2_replay");

    // 3: start on empty store, then write+start in one cycle
    clear();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t3_empty_state", 32'(bus.state), 32'(IDLE));
    chk("t3_empty_busy",  32'(bus.busy),  32'd0);
    model_mem[0] = 20'h00001;
    model_count  = 1;
    push_words(1);
    exp_q.push_back(exp_done());
    bus.wr_valid = 1'b1;
    bus.wr_data  = 20'h00001;
    bus.start    = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.start    = 1'b0;
    drain("t3_same_cycle_replay");
    chk("t3_count", 32'(bus.count), 32'd1);

    // 4: stop at pc=3, then full replay
    clear();
    for (int i = 0; i < 8; i++) write_word(20'(32'hA0000 + i * 32'h1001));
    push_words(4);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    idle(3);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("t4_stop_valid", 32'(bus.instr_valid), 32'd0);
    chk("t4_stop_instr", 32'(bus.instr_out),   32'd0);
    chk("t4_stop_busy",  32'(bus.busy),        32'd0);
    chk("t4_stop_done",  32'(bus.done),        32'd0);
    chk("t4_stop_state", 32'(bus.state),       32'(IDLE));
    step();
    chk("t4_no_late_done", 32'(bus.done), 32'd0);
    drain("t4_stop_partial");
    start_run("t4_restart");

    // 5: clr beats write; clr beats start
    bus.clr      = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 20'h55555;
    step();
    bus.clr      = 1'b0;
    bus.wr_valid = 1'b0;
    model_count  = 0;
    chk("t5_clr_drops_write", 32'(bus.count), 32'd0);
    write_word(20'h00A0A);
    write_word(20'h00B0B);
    chk("t5_count2", 32'(bus.count), 32'd2);
    bus.clr   = 1'b1;
    bus.start = 1'b1;
    step();
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    model_count = 0;
    chk("t5_clr_start_state", 32'(bus.state), 32'(IDLE));
    chk("t5_clr_start_count", 32'(bus.count), 32'd0);
    step();
    chk("t5_clr_start_busy", 32'(bus.busy), 32'd0);

    // 6: async reset mid-run at pc=5
    for (int i = 0; i < 8; i++) write_word(20'(32'hC0000 + i * 32'h30));
    push_words(5);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    model_count = 0;
    chk("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6_rst_instr", 32'(bus.instr_out),   32'd0);
    chk("t6_rst_pc",    32'(bus.pc),          32'd0);
    chk("t6_rst_count", 32'(bus.count),       32'd0);
    chk("t6_rst_busy",  32'(bus.busy),        32'd0);
    chk("t6_rst_done",  32'(bus.done),        32'd0);
    chk("t6_seen_before_rst", 32'(exp_q.size()), 32'd0);
    #4;
    rst_n = 1'b1;
    step();
    chk("t6_wr_ready_after", 32'(bus.wr_ready), 32'd1);
    chk("t6_count_after",    32'(bus.count),    32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
